frame_move_scheduler: RTL and testbench

- Per-frame scheduler that shares the single sprite-position update path between NUM_REQ movement requesters (player input, ghost AIs).
- Detects the rising edge of the VGA generator's `refresh_image` output.
- In that vertical-blank window, grants queued move requests round-robin and applies them to shadow positions.
- Commits all positions atomically to `pos_out`. Slot 0 drives the generator's `position_data`, so the display never sees a mid-frame position change.

---
 rtl/frame_move_scheduler_if.sv | 11 +
 rtl/frame_move_scheduler.sv | 150 +++++++++++++++
 tb/tb_frame_move_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_move_scheduler_if.sv
// Requester-side handshake bundle for frame_move_scheduler: move requests in, one-hot grants out.
interface frame_move_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [2*NUM_REQ-1:0] req_dir;
    logic [NUM_REQ-1:0]   req_ack;

    modport master (output req_valid, output req_dir, input req_ack);
    modport slave  (input req_valid, input req_dir, output req_ack);
endinterface

// File: rtl/frame_move_scheduler.sv
// Once per frame, grants queued sprite moves round-robin and commits all positions atomically.
// Optional macro FRAME_MOVE_WRAP_EN: x axis wraps around (tunnel) instead of clamping.
module frame_move_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_GRANTS = 4,
    parameter int STEP       = 2,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int SPRITE     = 16,
    parameter int X_INIT     = 312,
    parameter int Y_INIT     = 232
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   refresh_image,
    frame_move_scheduler_if.slave  bus,
    output logic [32*NUM_REQ-1:0]  pos_out,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_GRANTS + 1);
    localparam logic [15:0] XMAX   = 16'(H_ACTIVE - SPRITE);
    localparam logic [15:0] YMAX   = 16'(V_ACTIVE - SPRITE);
    localparam logic [15:0] STEP16 = 16'(STEP);
    localparam logic [31:0] INIT_POS = {16'(Y_INIT), 16'(X_INIT)};

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t               state_q, state_d;
    logic                 refresh_d_q;
    logic                 frame_edge;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [NUM_REQ-1:0]   granted_q;
    logic [31:0]          shadow_q [NUM_REQ];
    logic                 found;
    logic [PTR_W-1:0]     sel;
    logic [1:0]           dir_sel;
    logic                 grant;
    int                   idx;

    // Saturating (or x-wrapping) one-step move of a packed {y, x} position.
    function automatic logic [31:0] apply_move(input logic [31:0] pos, input logic [1:0] dir);
        logic [15:0] x, y;
        logic [16:0] xs, ys;
        x  = pos[15:0];
        y  = pos[31:16];
        xs = {1'b0, x} + {1'b0, STEP16};
        ys = {1'b0, y} + {1'b0, STEP16};
        case (dir)
            2'b00: y = (y < STEP16) ? 16'd0 : y - STEP16;
            2'b01: y = (ys > {1'b0, YMAX}) ? YMAX : ys[15:0];
`ifdef FRAME_MOVE_WRAP_EN
            2'b10: x = (x < STEP16) ? XMAX : x - STEP16;
            2'b11: x = (xs > {1'b0, XMAX}) ? 16'd0 : xs[15:0];
`else
            2'b10: x = (x < STEP16) ? 16'd0 : x - STEP16;
            2'b11: x = (xs > {1'b0, XMAX}) ? XMAX : xs[15:0];
`endif
            default: ;
        endcase
        return {y, x};
    endfunction

    assign frame_edge = refresh_image & ~refresh_d_q;

    // First pending, not-yet-granted requester at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req_valid[idx] && !granted_q[idx]) begin
                found = 1'b1;
                sel   = PTR_W'(idx);
            end
        end
    end

    assign dir_sel = bus.req_dir[2*int'(sel) +: 2];
    assign grant   = (state_q == SCAN) && found && (count_q < CNT_W'(MAX_GRANTS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_edge) state_d = SCAN;
            SCAN:    if (!grant)     state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ack = '0;
        if (grant) bus.req_ack = NUM_REQ'(1) << sel;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_d_q <= 1'b0;
            rr_ptr_q    <= '0;
            count_q     <= '0;
            granted_q   <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                shadow_q[i]          <= INIT_POS;
                pos_out[32*i +: 32]  <= INIT_POS;
            end
        end else begin
            refresh_d_q <= refresh_image;
            busy        <= (state_d != IDLE);
            frame_done  <= (state_q == COMMIT);
            if (frame_edge && state_q != IDLE) overrun <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (frame_edge) begin
                        granted_q <= '0;
                        count_q   <= '0;
                    end
                end
                SCAN: begin
                    if (grant) begin
                        shadow_q[sel]  <= apply_move(shadow_q[sel], dir_sel);
                        granted_q[sel] <= 1'b1;
                        count_q        <= count_q + 1'b1;
                        rr_ptr_q       <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
                    end
                end
                COMMIT: begin
                    // Single-cycle copy keeps the display from ever seeing a partial frame.
                    for (int i = 0; i < NUM_REQ; i++) pos_out[32*i +: 32] <= shadow_q[i];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_move_scheduler.sv
// Scoreboard bench for frame_move_scheduler: two instances (MAX_GRANTS 4 and 2) share stimulus.
module tb_frame_move_scheduler;

    localparam int NR   = 4;
    localparam int STEP = 2;
    localparam int XMAX = 624;
    localparam int YMAX = 464;
    localparam int XI   = 312;
    localparam int YI   = 232;
    localparam int MAXG0 = 4;
    localparam int MAXG1 = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic refresh = 1'b0;
    logic [NR-1:0]   drv_valid = '0;
    logic [2*NR-1:0] drv_dir = '0;

    always #5 clk = ~clk;

    frame_move_scheduler_if #(.NUM_REQ(NR)) bus0 ();
    frame_move_scheduler_if #(.NUM_REQ(NR)) bus1 ();

    assign bus0.req_valid = drv_valid;
    assign bus0.req_dir   = drv_dir;
    assign bus1.req_valid = drv_valid;
    assign bus1.req_dir   = drv_dir;

    logic [32*NR-1:0] pos_o [2];
    logic             busy_o [2];
    logic             fd_o [2];
    logic             ovr_o [2];
    logic [NR-1:0]    ack_o [2];

    assign ack_o[0] = bus0.req_ack;
    assign ack_o[1] = bus1.req_ack;

    frame_move_scheduler #(.NUM_REQ(NR), .MAX_GRANTS(MAXG0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .refresh_image(refresh), .bus(bus0),
        .pos_out(pos_o[0]), .busy(busy_o[0]), .frame_done(fd_o[0]), .overrun(ovr_o[0]));

    frame_move_scheduler #(.NUM_REQ(NR), .MAX_GRANTS(MAXG1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .refresh_image(refresh), .bus(bus1),
        .pos_out(pos_o[1]), .busy(busy_o[1]), .frame_done(fd_o[1]), .overrun(ovr_o[1]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: positions, round-robin pointer and sticky overrun per instance.
    int mx [2][NR];
    int my [2][NR];
    int mrr [2];
    bit exp_ovr = 1'b0;

    int               ackq [2][$];
    logic [32*NR-1:0] frq  [2][$];
    int               cycq [2][$];
    int               kq   [2][$];
    int               bcnt [2];

    logic [NR-1:0] fvec [NR+1];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int maxg(input int d);
        return (d == 0) ? MAXG0 : MAXG1;
    endfunction

    function automatic logic [32*NR-1:0] mpack(input int d);
        logic [32*NR-1:0] r;
        for (int i = 0; i < NR; i++) r[32*i +: 32] = {16'(my[d][i]), 16'(mx[d][i])};
        return r;
    endfunction

    function automatic logic [32*NR-1:0] init_vec();
        logic [32*NR-1:0] r;
        for (int i = 0; i < NR; i++) r[32*i +: 32] = {16'(YI), 16'(XI)};
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mrr[d] = 0;
            for (int i = 0; i < NR; i++) begin
                mx[d][i] = XI;
                my[d][i] = YI;
            end
        end
        exp_ovr = 1'b0;
    endtask

    task automatic model_move(input int d, input int i, input logic [1:0] dir);
        case (dir)
            2'b00: my[d][i] = (my[d][i] < STEP) ? 0 : my[d][i] - STEP;
            2'b01: my[d][i] = (my[d][i] + STEP > YMAX) ? YMAX : my[d][i] + STEP;
`ifdef FRAME_MOVE_WRAP_EN
            2'b10: mx[d][i] = (mx[d][i] < STEP) ? XMAX : mx[d][i] - STEP;
            2'b11: mx[d][i] = (mx[d][i] + STEP > XMAX) ? 0 : mx[d][i] + STEP;
`else
            2'b10: mx[d][i] = (mx[d][i] < STEP) ? 0 : mx[d][i] - STEP;
            2'b11: mx[d][i] = (mx[d][i] + STEP > XMAX) ? XMAX : mx[d][i] + STEP;
`endif
            default: ;
        endcase
    endtask

    // Grant j of a frame sees the request vector fvec[j]; push the whole expected frame.
    task automatic model_frame(input logic [2*NR-1:0] dirs, input int edge_cyc);
        for (int d = 0; d < 2; d++) begin
            bit [NR-1:0] granted;
            int k;
            granted = '0;
            k = 0;
            while (k < maxg(d)) begin
                int pick;
                pick = -1;
                for (int off = 0; off < NR; off++) begin
                    int s;
                    s = (mrr[d] + off) % NR;
                    if (pick < 0 && fvec[k][s] && !granted[s]) pick = s;
                end
                if (pick < 0) break;
                granted[pick] = 1'b1;
                model_move(d, pick, dirs[2*pick +: 2]);
                ackq[d].push_back(pick);
                mrr[d] = (pick + 1) % NR;
                k++;
            end
            frq[d].push_back(mpack(d));
            cycq[d].push_back(edge_cyc + k + 3);
            kq[d].push_back(k);
        end
    endtask

    task automatic run_frame(input logic [2*NR-1:0] dirs, input bit double_edge);
        int n;
        @(posedge clk); #1;
        n = cyc;
        drv_valid = fvec[0];
        drv_dir   = dirs;
        refresh   = 1'b1;
        model_frame(dirs, n);
        for (int c = 1; c <= NR + 1; c++) begin
            @(posedge clk); #1;
            if (c >= 2) drv_valid = fvec[c-1];
            if (double_edge) begin
                if (c == 1) refresh = 1'b0;
                if (c == 2) begin
                    refresh = 1'b1;
                    exp_ovr = 1'b1;
                end
                if (c == 4) refresh = 1'b0;
            end else if (c == 3) begin
                refresh = 1'b0;
            end
        end
        drv_valid = '0;
        repeat (9) @(posedge clk);
    endtask

    task automatic fill_vec(input logic [NR-1:0] v);
        for (int j = 0; j <= NR; j++) fvec[j] = v;
    endtask

    // Monitor: pops expectations whenever an instance acks or finishes a frame.
    always @(negedge clk) begin
        if (!reset_n) begin
            bcnt[0] = 0;
            bcnt[1] = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (busy_o[d]) bcnt[d]++;
                if (ack_o[d] != '0) begin
                    if (ackq[d].size() == 0) chk($sformatf("spurious_ack%0d", d), ack_o[d], 0);
                    else begin
                        int e;
                        e = ackq[d].pop_front();
                        chk($sformatf("ack%0d", d), ack_o[d], NR'(1) << e);
                    end
                end
                if (fd_o[d]) begin
                    if (frq[d].size() == 0) chk($sformatf("spurious_frame_done%0d", d), fd_o[d], 0);
                    else begin
                        logic [32*NR-1:0] ep;
                        int ec, ek;
                        ep = frq[d].pop_front();
                        ec = cycq[d].pop_front();
                        ek = kq[d].pop_front();
                        chk($sformatf("pos_out%0d", d), pos_o[d], ep);
                        chk($sformatf("frame_done_cycle%0d", d), cyc, ec);
                        chk($sformatf("busy_cycles%0d", d), bcnt[d], ek + 2);
                        chk($sformatf("overrun%0d", d), ovr_o[d], exp_ovr);
                    end
                    bcnt[d] = 0;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_pos%0d", tag, d), pos_o[d], init_vec());
            chk($sformatf("%s_busy%0d", tag, d), busy_o[d], 0);
            chk($sformatf("%s_fd%0d", tag, d), fd_o[d], 0);
            chk($sformatf("%s_ovr%0d", tag, d), ovr_o[d], 0);
            chk($sformatf("%s_ack%0d", tag, d), ack_o[d], 0);
        end
    endtask

    initial begin
        logic [NR-1:0] base;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // No requests: empty scan, unchanged positions.
        fill_vec('0);
        run_frame('0, 1'b0);

        // All valid, all right, two frames: full sweep vs. limited grants carried over.
        fill_vec('1);
        run_frame({NR{2'b11}}, 1'b0);
        run_frame({NR{2'b11}}, 1'b0);

        // Second rising edge while scanning.
        fill_vec('1);
        run_frame({2'b00, 2'b01, 2'b10, 2'b11}, 1'b1);
        chk("overrun_sticky0", ovr_o[0], 1);
        chk("overrun_sticky1", ovr_o[1], 1);

        // Reset in the cycle after the first ack.
        fill_vec('1);
        @(posedge clk); #1;
        drv_valid = '1;
        drv_dir   = {NR{2'b01}};
        refresh   = 1'b1;
        model_frame(drv_dir, cyc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        refresh = 1'b0;
        #1;
        check_reset_outputs("midscan_reset");
        for (int d = 0; d < 2; d++) begin
            ackq[d].delete();
            frq[d].delete();
            cycq[d].delete();
            kq[d].delete();
        end
        model_reset();
        drv_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        fill_vec(4'b0101);
        run_frame({NR{2'b10}}, 1'b0);

        // Drive every slot into its boundary: left, down, right, up.
        fill_vec('1);
        for (int f = 0; f < 330; f++) run_frame({2'b00, 2'b11, 2'b01, 2'b10}, 1'b0);
`ifndef FRAME_MOVE_WRAP_EN
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("clamp_left%0d", d),  pos_o[d][15:0],   0);
            chk($sformatf("clamp_down%0d", d),  pos_o[d][63:48],  YMAX);
            chk($sformatf("clamp_right%0d", d), pos_o[d][79:64],  XMAX);
            chk($sformatf("clamp_up%0d", d),    pos_o[d][127:112], 0);
        end
`endif

        // Random requests, including valids that change during the scan.
        for (int f = 0; f < 150; f++) begin
            base = NR'($urandom_range(0, (1 << NR) - 1));
            for (int j = 0; j <= NR; j++) begin
                if ($urandom_range(0, 3) == 0) base = base ^ NR'($urandom_range(0, (1 << NR) - 1));
                fvec[j] = base;
            end
            run_frame((2*NR)'($urandom()), 1'b0);
        end

        repeat (5) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("acks_outstanding%0d", d), ackq[d].size(), 0);
            chk($sformatf("frames_outstanding%0d", d), frq[d].size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
